id_issue_queue: RTL
===================

# id_issue_queue

Parametrised decode-to-issue buffer: a multi-lane, multi-entry successor of the single-entry ID/issue pipeline register. It accepts up to NR_LANES decoded scoreboard entries per cycle from the decoder lanes, stores up to DEPTH of them in program order, and presents the oldest entry to the issue stage. Flush support and same-cycle slot reuse on acknowledge let the front end run ahead of issue without bubbles.

## Interface
- DATA_W, default 256: width of one decoded entry (packed scoreboard entry).
- NR_LANES, default 2: decoder lanes offered per cycle; legal 1..4, must be ≤ DEPTH.
- DEPTH, default 4: queue entries; power of two, ≥ 2.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  discard all stored entries and all entries offered this cycle.
- in_data_i  in  NR_LANES×DATA_W  decoded entries; lane 0 is the oldest.
- in_ctrl_flow_i  in  NR_LANES  per-lane control-flow flag, stored with its entry.
- in_valid_i  in  NR_LANES  per-lane valid; must be a contiguous prefix (lane k valid implies lanes 0..k-1 valid).
- in_ready_o  out  NR_LANES  per-lane accept; always a prefix mask.
- out_data_o  out  DATA_W  oldest stored entry.
- out_ctrl_flow_o  out  1  control-flow flag of the oldest entry.
- out_valid_o  out  1  queue non-empty.
- out_ack_i  in  1  issue stage consumes the oldest entry this cycle.
- count_o  out  $clog2(DEPTH+1)  number of stored entries.

## Operation
- Storage: DEPTH-entry circular buffer; read pointer, write pointer (both $clog2(DEPTH) bits, natural wrap), count register.
- Effective ack: ack = out_ack_i & out_valid_o; out_ack_i while empty is ignored.
- Free slots this cycle: free = DEPTH − count + ack. Freed head slot is reusable in the same cycle.
- in_ready_o[k] = (free > k), combinational from count and out_ack_i. No dependency on in_valid_i.
- Accepted lanes: n_acc = number of k with in_valid_i[k] & in_ready_o[k]. Lane k is written to slot (wptr + k) mod DEPTH.
- Update (no flush): rptr += ack; wptr += n_acc; count = count + n_acc − ack.
- out_data_o / out_ctrl_flow_o driven from the slot at rptr. Contents undefined (stale) when out_valid_o = 0.
- Flush: when flush_i = 1, next count = 0 and rptr = wptr = 0. No lane is written. in_ready_o is forced all-ones so the fetch side drains. Flush overrides ack and accept in the same cycle.
- Illegal input: a non-prefix in_valid_i is a protocol violation, flagged by an assertion; behaviour is otherwise unspecified.
- Storage array has no reset. Pointers and count reset to 0.

## Timing
- Reset values: count_o = 0, out_valid_o = 0, out_ctrl_flow_o = 0 (slot 0 contents cleared only for the flag bit), in_ready_o = all-ones (free = DEPTH).
- Latency: an entry accepted in cycle t is visible on out_* in cycle t+1 at the earliest (empty queue). There is no combinational bypass from in_* to out_*.
- Throughput: one entry out per cycle, up to NR_LANES in per cycle.
- Full (count = DEPTH) with out_ack_i = 1: in_ready_o[0] = 1; exactly one lane is accepted.
- Full with out_ack_i = 0: in_ready_o = 0.
- Empty with out_ack_i = 1: no effect.
- Wrap-around: a multi-lane write that crosses slot DEPTH−1 continues at slot 0 in the same cycle.
- Asynchronous reset asserted mid-operation empties the queue immediately. The first accept after release lands in slot 0.
- Critical path: out_ack_i → in_ready_o is combinational. The issue stage must drive out_ack_i from registered or early logic.

## Test plan
- Reset/basic: release reset, offer lanes 0,1 with data 0xA,0xB, ack held 0 → in_ready_o = 2'b11; next cycle count_o = 2, out_data_o = 0xA, out_valid_o = 1.
- Fill/full: DEPTH = 4, offer 2 lanes for 2 cycles with no ack → count_o = 4, in_ready_o = 0. Assert out_ack_i with lane 0 valid → in_ready_o = 2'b01, count stays 4, head advances to the 2nd entry.
- Wrap-around: advance pointers to wptr = 3 via pushes and acks, then push 0x5,0x6 → stored at slots 3 and 0; outputs pop in order 0x5, 0x6.
- Flush with simultaneous activity: count = 3, out_ack_i = 1, two lanes valid, flush_i = 1 → in_ready_o = 2'b11; next cycle count_o = 0 and out_valid_o = 0. The next push appears at slot 0.
- Spurious ack: empty queue, out_ack_i = 1 and lane 0 valid with 0x7 → next cycle count_o = 1, out_data_o = 0x7 (ack ignored).
- Random stress: random prefix-valid offers and random acks with a scoreboard reference model. Output order equals accept order, with no loss or duplication across 10k cycles including random flushes.

Source files
------------

// File: rtl/id_issue_queue_if.sv
// Decoder/issue-side bundle of the decode-to-issue queue.
// Master drives offers, flush and ack; slave (the queue) returns ready, head entry and occupancy.
interface id_issue_queue_if #(
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned NR_LANES = 2,
    parameter int unsigned DEPTH    = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                               flush_i;
    logic [NR_LANES-1:0][DATA_W-1:0]    in_data_i;
    logic [NR_LANES-1:0]                in_ctrl_flow_i;
    logic [NR_LANES-1:0]                in_valid_i;
    logic [NR_LANES-1:0]                in_ready_o;
    logic [DATA_W-1:0]                  out_data_o;
    logic                               out_ctrl_flow_o;
    logic                               out_valid_o;
    logic                               out_ack_i;
    logic [CW-1:0]                      count_o;

    modport master (
        output flush_i, in_data_i, in_ctrl_flow_i, in_valid_i, out_ack_i,
        input  in_ready_o, out_data_o, out_ctrl_flow_o, out_valid_o, count_o
    );

    modport slave (
        input  flush_i, in_data_i, in_ctrl_flow_i, in_valid_i, out_ack_i,
        output in_ready_o, out_data_o, out_ctrl_flow_o, out_valid_o, count_o
    );
endinterface

// File: rtl/id_issue_queue.sv
// Multi-lane decode-to-issue FIFO: up to NR_LANES in per cycle, oldest entry presented to issue.
// Latency: accepted entry visible on out_* next cycle at the earliest; no in->out bypass.
// Backpressure: in_ready_o is a prefix mask of free slots, counting the head slot freed by ack.
module id_issue_queue #(
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned NR_LANES = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    id_issue_queue_if.slave  q
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]   mem_dat [DEPTH];
    logic [DEPTH-1:0]    mem_cf;
    logic [PW-1:0]       rptr_q;
    logic [PW-1:0]       wptr_q;
    logic [CW-1:0]       count_q;

    logic                ack;
    logic [31:0]         free;
    logic [NR_LANES-1:0] rdy;
    logic [NR_LANES-1:0] acc;
    logic [CW-1:0]       n_acc;
    logic [PW-1:0]       widx [NR_LANES];

    always_comb begin
        ack   = q.out_ack_i & (count_q != '0);
        free  = DEPTH - 32'(count_q) + 32'(ack);
        rdy   = '0;
        n_acc = '0;
        for (int k = 0; k < int'(NR_LANES); k++) begin
            rdy[k]  = q.flush_i | (free > 32'(k));
            widx[k] = wptr_q + PW'(k);
        end
        // Flush discards this cycle's offers even though ready is forced high.
        acc = q.in_valid_i & rdy & {NR_LANES{~q.flush_i}};
        for (int k = 0; k < int'(NR_LANES); k++) begin
            if (acc[k]) n_acc = n_acc + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            mem_cf  <= '0;
        end else begin
            if (q.flush_i) begin
                rptr_q  <= '0;
                wptr_q  <= '0;
                count_q <= '0;
            end else begin
                rptr_q  <= rptr_q + PW'(ack);
                wptr_q  <= wptr_q + PW'(n_acc);
                count_q <= count_q + n_acc - CW'(ack);
            end
            for (int k = 0; k < int'(NR_LANES); k++) begin
                if (acc[k]) mem_cf[widx[k]] <= q.in_ctrl_flow_i[k];
            end
        end
    end

    // Payload storage carries no reset; stale contents are masked by out_valid_o.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < int'(NR_LANES); k++) begin
            if (acc[k]) mem_dat[widx[k]] <= q.in_data_i[k];
        end
    end

    assign q.in_ready_o      = rdy;
    assign q.out_data_o      = mem_dat[rptr_q];
    assign q.out_ctrl_flow_o = mem_cf[rptr_q];
    assign q.out_valid_o     = (count_q != '0);
    assign q.count_o         = count_q;

    logic [NR_LANES:0] vld_ext;
    logic              prefix_ok;
    assign vld_ext   = {1'b0, q.in_valid_i};
    assign prefix_ok = ((vld_ext & (vld_ext + (NR_LANES+1)'(1))) == '0);

    a_valid_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni) prefix_ok)
        else $error("in_valid_i is not a contiguous prefix");
endmodule
